// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants for the push-button front end.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int DB_CYCLES_DEF     = 500000;
  localparam int REPEAT_DELAY_DEF  = 25000000;
  localparam int REPEAT_PERIOD_DEF = 5000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw active-low keys in, cleaned levels, strobes and FSM state out.
interface button_conditioner_if;
  import button_pkg::*;

  // No handshake: *_pulse are single-cycle strobes with no ready/backpressure,
  // *_clean_n are registered levels, *_state mirror each channel's FSM.
  logic       btn_decrement;
  logic       btn_reset;
  logic       dec_clean_n;
  logic       rst_clean_n;
  logic       dec_pulse;
  logic       rst_pulse;
  btn_state_t dec_state;
  btn_state_t rst_state;

  modport master (
    output btn_decrement, btn_reset,
    input  dec_clean_n, rst_clean_n, dec_pulse, rst_pulse, dec_state, rst_state
  );

  modport slave (
    input  btn_decrement, btn_reset,
    output dec_clean_n, rst_clean_n, dec_pulse, rst_pulse, dec_state, rst_state
  );

endinterface

// File: rtl/button_conditioner_channel.sv
// One key: 2-FF synchronizer, debounce FSM, optional hold-to-repeat strobes.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       clean_n,
  output logic       pulse,
  output btn_state_t state_dbg
);

  localparam int CNT_W = $clog2(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TOP    = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic             s1, s2;
  btn_state_t       state, state_n;
  logic [CNT_W-1:0] db_cnt, db_cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n, rep_next;
  logic             pulse_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      state   <= IDLE;
      db_cnt  <= '0;
      rep_cnt <= '0;
      pulse   <= 1'b0;
      clean_n <= 1'b1;
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      state   <= state_n;
      db_cnt  <= db_cnt_n;
      rep_cnt <= rep_cnt_n;
      pulse   <= pulse_n;
      clean_n <= !(state_n == PRESSED || state_n == RELEASE_WAIT);
    end
  end

  always_comb begin
    state_n   = state;
    db_cnt_n  = db_cnt;
    rep_cnt_n = rep_cnt;
    pulse_n   = 1'b0;
    rep_next  = (rep_cnt == REP_TOP) ? REP_TOP : rep_cnt + CNT_W'(1);
    unique case (state)
      IDLE: begin
        if (!s2) begin
          state_n  = PRESS_WAIT;
          db_cnt_n = '0;
        end
      end
      PRESS_WAIT: begin
        if (s2) begin
          state_n = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_n   = PRESSED;
          pulse_n   = 1'b1;
          rep_cnt_n = '0;
        end else begin
          db_cnt_n = db_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        // The leaving cycle still counts as held; a repeat that lands on it
        // is parked at REP_TOP and fires on return from a release glitch.
        if (s2) begin
          state_n   = RELEASE_WAIT;
          db_cnt_n  = '0;
          rep_cnt_n = rep_next;
        end else if (REPEAT_EN && rep_next == REP_TOP) begin
          pulse_n   = 1'b1;
          rep_cnt_n = REP_RELOAD;
        end else begin
          rep_cnt_n = rep_next;
        end
      end
      RELEASE_WAIT: begin
        if (!s2) begin
          state_n = PRESSED;
          if (REPEAT_EN && rep_cnt == REP_TOP) begin
            pulse_n   = 1'b1;
            rep_cnt_n = REP_RELOAD;
          end
        end else if (db_cnt == DB_LAST) begin
          state_n = IDLE;
        end else begin
          db_cnt_n = db_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: rtl/button_conditioner.sv
// Two independent key channels feeding the down-counter: decrement (with repeat) and reset.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  debounce_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_dec (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (bus.btn_decrement),
    .clean_n  (bus.dec_clean_n),
    .pulse    (bus.dec_pulse),
    .state_dbg(bus.dec_state)
  );

  debounce_channel #(
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b0)
  ) u_rst (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (bus.btn_reset),
    .clean_n  (bus.rst_clean_n),
    .pulse    (bus.rst_pulse),
    .state_dbg(bus.rst_state)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing against a run-length model.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  button_conditioner_if bus ();

  button_conditioner #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_dec  = 0;
  int cnt_rst  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Accepted level flips once the synchronized key has disagreed with it for
  // DB+1 consecutive samples. Repeats are scheduled on the count of held
  // (non-releasing) cycles since the press: RD, RD+RP, RD+2RP, ...
  logic [3:0] exp_q[$];
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_acc[2];
  int   m_run[2];
  int   m_v  [2];
  logic m_raw[2];
  logic m_pe [2];
  logic m_smp, m_acc0, m_steady0, m_press;

  always @(posedge clk) begin
    m_raw[0] = bus.btn_decrement;
    m_raw[1] = bus.btn_reset;
    for (int c = 0; c < 2; c++) begin
      m_pe[c] = 1'b0;
      if (!rst) begin
        m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_acc[c] = 1'b0; m_run[c] = 0; m_v[c] = 0;
      end else begin
        m_smp     = m_s2[c];
        m_acc0    = m_acc[c];
        m_steady0 = (m_run[c] == 0);
        m_press   = 1'b0;
        m_s2[c]   = m_s1[c];
        m_s1[c]   = m_raw[c];
        if ((m_smp == 1'b0) != m_acc[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_acc[c] = !m_acc[c];
            m_run[c] = 0;
            m_press  = m_acc[c];
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_press) begin
          m_v[c]  = 0;
          m_pe[c] = 1'b1;
        end else if (m_acc0) begin
          if (m_steady0) m_v[c]++;
          if (c == 0 && m_acc[c] && m_run[c] == 0 && m_v[c] >= RD && (m_v[c] - RD) % RP == 0)
            m_pe[c] = 1'b1;
        end
      end
    end
    exp_q.push_back({!m_acc[0], !m_acc[1], m_pe[0], m_pe[1]});
  end

  // ---------------- scoreboard ----------------
  logic [3:0] sb_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      check("dec_clean_n", bus.dec_clean_n, sb_e[3]);
      check("rst_clean_n", bus.rst_clean_n, sb_e[2]);
      check("dec_pulse",   bus.dec_pulse,   sb_e[1]);
      check("rst_pulse",   bus.rst_pulse,   sb_e[0]);
    end
    if (bus.dec_pulse === 1'b1) cnt_dec++;
    if (bus.rst_pulse === 1'b1) cnt_rst++;
  end

  // ---------------- driver ----------------
  task automatic drive(input logic dec, input logic rk, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      bus.btn_decrement = dec;
      bus.btn_reset     = rk;
      rst               = r;
    end
  endtask

  int base_dec, base_rst;

  task automatic mark();
    base_dec = cnt_dec;
    base_rst = cnt_rst;
  endtask

  task automatic count_check(input string tag, input int exp_dec, input int exp_rst);
    check({tag, "_dec_pulses"}, cnt_dec - base_dec, exp_dec);
    check({tag, "_rst_pulses"}, cnt_rst - base_rst, exp_rst);
  endtask

  initial begin
    int len;
    logic d, k, r;
    bus.btn_decrement = 1'b0;
    bus.btn_reset     = 1'b0;
    rst               = 1'b0;

    // 1: reset with keys low, then a full debounce after release of reset
    drive(1'b0, 1'b0, 1'b0, 2);
    check("reset_dec_clean_n", bus.dec_clean_n, 1'b1);
    check("reset_rst_clean_n", bus.rst_clean_n, 1'b1);
    check("reset_dec_pulse",   bus.dec_pulse,   1'b0);
    check("reset_rst_pulse",   bus.rst_pulse,   1'b0);
    mark();
    drive(1'b0, 1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 1'b1, 12);
    count_check("post_reset", 1, 1);

    // 2: clean press
    mark();
    drive(1'b0, 1'b1, 1'b1, 8);
    drive(1'b1, 1'b1, 1'b1, 12);
    count_check("clean", 1, 0);

    // 3: bounce
    mark();
    drive(1'b0, 1'b1, 1'b1, 3);
    drive(1'b1, 1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1'b1, 8);
    drive(1'b1, 1'b1, 1'b1, 12);
    count_check("bounce", 1, 0);

    // 4: hold both keys, 30 held cycles past the press
    mark();
    drive(1'b0, 1'b0, 1'b1, 35);
    drive(1'b1, 1'b1, 1'b1, 12);
    count_check("repeat", 8, 1);

    // 5: two-cycle release glitch while held
    mark();
    drive(1'b0, 1'b1, 1'b1, 20);
    drive(1'b1, 1'b1, 1'b1, 2);
    drive(1'b0, 1'b1, 1'b1, 20);
    drive(1'b1, 1'b1, 1'b1, 12);
    count_check("glitch", 10, 0);

    // 6: reset in the middle of press debounce
    mark();
    drive(1'b0, 1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 1'b0, 1);
    check("midrst_dec_clean_n", bus.dec_clean_n, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 10);
    drive(1'b1, 1'b1, 1'b1, 12);
    count_check("midrst", 1, 0);

    // random bouncing on both keys with occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      len = $urandom_range(1, 12);
      d   = 1'($urandom_range(0, 1));
      k   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      if (!r) drive(d, k, 1'b0, 1);
      drive(d, k, 1'b1, len);
    end
    drive(1'b1, 1'b1, 1'b1, 12);
    check("final_dec_clean_n", bus.dec_clean_n, 1'b1);
    check("final_rst_clean_n", bus.rst_clean_n, 1'b1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
